// File: rtl/dma_priority_resolver_pkg.sv
// Shared DMA types: channel count, index width and the one-hot priority FSM states.
package dmaPkg;

    localparam int NUM_CH = 4;
    localparam int CH_W   = $clog2(NUM_CH);

    typedef enum logic [2:0] {
        IDLE   = 3'b001,
        LOCKED = 3'b010,
        SERVE  = 3'b100
    } prioState_e;

    // One-hot acknowledge vector for a channel index.
    function automatic logic [NUM_CH-1:0] ch_onehot(input logic [CH_W-1:0] ch);
        return {{(NUM_CH-1){1'b0}}, 1'b1} << ch;
    endfunction

endpackage

// File: rtl/dma_priority_resolver_rr_pick.sv
// Combinational priority picker: first set request starting at top_ch, wrapping mod 4.
module dma_rr_pick
    import dmaPkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   top_ch,
    output logic [CH_W-1:0]   winner,
    output logic              any
);

    logic [NUM_CH-1:0] rot_s;
    logic [CH_W-1:0]   off_s;

    // Rotate so top_ch lands at bit 0, take the lowest set bit, then undo the rotation.
    always_comb begin
        rot_s = NUM_CH'({req, req} >> top_ch);
        off_s = '0;
        casez (rot_s)
            4'b???1: off_s = 2'd0;
            4'b??10: off_s = 2'd1;
            4'b?100: off_s = 2'd2;
            4'b1000: off_s = 2'd3;
            default: off_s = 2'd0;
        endcase
        winner = top_ch + off_s;
        any    = |req;
    end

endmodule

// File: rtl/dma_priority_resolver.sv
// DMA channel arbitration: normalize/mask DREQ, lock one winner, drive DACK during service.
// Optional DMA_ROTATING_PRIORITY_EN compiles in the rotating topCh pointer.
module dma_priority_resolver
    import dmaPkg::*;
(
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NUM_CH-1:0] DREQ,
    input  logic              dreqSenseHigh,
    input  logic              dackSenseHigh,
    input  logic [NUM_CH-1:0] maskReg,
    input  logic              rotatingPriority,
    input  logic              assertDACK,
    input  logic              intEOP,
    output logic [NUM_CH-1:0] DACK,
    output logic              grantValid,
    output logic [CH_W-1:0]   grantChannel,
    output logic [NUM_CH-1:0] pendingReq
);

    logic [NUM_CH-1:0] req_s;
    logic [NUM_CH-1:0] pend_r;
    prioState_e        state_r;
    prioState_e        state_nxt_s;
    logic [CH_W-1:0]   grant_r;
    logic [CH_W-1:0]   grant_nxt_s;
    logic              gvalid_r;
    logic              rotate_s;
    logic [CH_W-1:0]   top_ch_s;
    logic [CH_W-1:0]   winner_s;
    logic              any_s;
    logic [NUM_CH-1:0] dack_act_s;

    // Request normalization to active-high, then masking.
    always_comb begin
        req_s = (dreqSenseHigh ? DREQ : ~DREQ) & ~maskReg;
    end

    // Single synchronizer stage for the filtered requests.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pend_r <= '0;
        end else begin
            pend_r <= req_s;
        end
    end

    dma_rr_pick u_pick (
        .req    (pend_r),
        .top_ch (top_ch_s),
        .winner (winner_s),
        .any    (any_s)
    );

    // Next-state logic; rotate_s marks the SERVE exit where the priority pointer moves.
    always_comb begin
        state_nxt_s = state_r;
        grant_nxt_s = grant_r;
        rotate_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (any_s) begin
                    state_nxt_s = LOCKED;
                    grant_nxt_s = winner_s;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOCKED: begin
                if (assertDACK) begin
                    state_nxt_s = SERVE;
                end else if (!pend_r[grant_r]) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = LOCKED;
                end
            end
            SERVE: begin
                if (intEOP || !assertDACK) begin
                    state_nxt_s = IDLE;
                    rotate_s    = 1'b1;
                end else begin
                    state_nxt_s = SERVE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM state, locked channel and grant flag registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r  <= IDLE;
            grant_r  <= '0;
            gvalid_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            grant_r  <= grant_nxt_s;
            gvalid_r <= (state_nxt_s != IDLE);
        end
    end

`ifdef DMA_ROTATING_PRIORITY_EN
    logic [CH_W-1:0] top_ch_r;

    // Priority pointer: serviced channel becomes lowest when rotating, else back to ch0.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            top_ch_r <= '0;
        end else if (rotate_s) begin
            top_ch_r <= rotatingPriority ? (grant_r + CH_W'(1)) : '0;
        end else begin
            top_ch_r <= top_ch_r;
        end
    end

    assign top_ch_s = top_ch_r;
`else
    logic [1:0] unused_cfg_s;

    assign top_ch_s     = '0;
    assign unused_cfg_s = {rotatingPriority, rotate_s};
`endif

    // DACK follows assertDACK in the same cycle so it tracks S1/S2 without delay.
    always_comb begin
        if (assertDACK && (state_r != IDLE)) begin
            dack_act_s = ch_onehot(grant_r);
        end else begin
            dack_act_s = '0;
        end
        DACK = dackSenseHigh ? dack_act_s : ~dack_act_s;
    end

    assign grantValid   = gvalid_r;
    assign grantChannel = grant_r;
    assign pendingReq   = pend_r;

endmodule

// File: tb/tb_dma_priority_resolver.sv
// Self-checking bench for dma_priority_resolver: directed scenarios plus random traffic vs a behavioural model.
module tb_dma_priority_resolver;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [3:0] DREQ;
    logic       dreqSenseHigh;
    logic       dackSenseHigh;
    logic [3:0] maskReg;
    logic       rotatingPriority;
    logic       assertDACK;
    logic       intEOP;
    logic [3:0] DACK;
    logic       grantValid;
    logic [1:0] grantChannel;
    logic [3:0] pendingReq;

    int n_cmp = 0;
    int n_mis = 0;

`ifdef DMA_ROTATING_PRIORITY_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    // Behavioural model: phase 0 = idle, 1 = locked, 2 = in service.
    logic [3:0] m_pend = 4'h0;
    int         m_phase = 0;
    int         m_gnt = 0;
    int         m_top = 0;
    bit         armed = 1'b0;
    int         exp_order [4];

    dma_priority_resolver dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .DREQ             (DREQ),
        .dreqSenseHigh    (dreqSenseHigh),
        .dackSenseHigh    (dackSenseHigh),
        .maskReg          (maskReg),
        .rotatingPriority (rotatingPriority),
        .assertDACK       (assertDACK),
        .intEOP           (intEOP),
        .DACK             (DACK),
        .grantValid       (grantValid),
        .grantChannel     (grantChannel),
        .pendingReq       (pendingReq)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] p, input int top);
        for (int k = 0; k < 4; k++) begin
            int c;
            c = (top + k) % 4;
            if (p[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_dack();
        logic [3:0] act;
        act = (assertDACK && m_phase != 0) ? (4'b0001 << m_gnt) : 4'b0000;
        return dackSenseHigh ? act : ~act;
    endfunction

    task automatic model_edge();
        logic [3:0] np;
        int c;
        np = (dreqSenseHigh ? DREQ : ~DREQ) & ~maskReg;
        if (RESET) begin
            m_pend = 4'h0; m_phase = 0; m_gnt = 0; m_top = 0;
        end else begin
            case (m_phase)
                0: begin
                    c = pick(m_pend, m_top);
                    if (c >= 0) begin
                        m_gnt = c;
                        m_phase = 1;
                    end
                end
                1: begin
                    if (assertDACK) m_phase = 2;
                    else if (!m_pend[m_gnt]) m_phase = 0;
                end
                default: begin
                    if (intEOP || !assertDACK) begin
                        m_phase = 0;
                        m_top = (ROT_EN && rotatingPriority) ? (m_gnt + 1) % 4 : 0;
                    end
                end
            endcase
            m_pend = np;
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
        armed = 1'b1;
        chk("valid", {31'd0, grantValid}, {31'd0, m_phase != 0});
        chk("chan", {30'd0, grantChannel}, m_gnt);
        chk("pend", {28'd0, pendingReq}, {28'd0, m_pend});
        chk("dack", {28'd0, DACK}, {28'd0, exp_dack()});
    endtask

    // Let new inputs settle; DACK must react in the same cycle.
    task automatic settle();
        #1;
        if (armed) chk("dack_comb", {28'd0, DACK}, {28'd0, exp_dack()});
    endtask

    task automatic do_reset();
        RESET = 1'b1; settle(); tick();
        RESET = 1'b0; settle();
    endtask

    task automatic serve_one(output int ch);
        int w;
        w = 0;
        while (!grantValid && w < 10) begin
            tick();
            w++;
        end
        chk("grant_wait", {31'd0, grantValid}, 32'd1);
        ch = int'(grantChannel);
        assertDACK = 1'b1; settle(); tick();
        intEOP = 1'b1; settle(); tick();
        intEOP = 1'b0; assertDACK = 1'b0; settle();
    endtask

    initial begin
        int ch;
`ifdef DMA_ROTATING_PRIORITY_EN
        exp_order = '{3, 0, 1, 2};
`else
        exp_order = '{0, 0, 0, 0};
`endif
        RESET = 1'b1; DREQ = 4'h0; maskReg = 4'h0; dreqSenseHigh = 1'b1; dackSenseHigh = 1'b1;
        rotatingPriority = 1'b0; assertDACK = 1'b0; intEOP = 1'b0;
        tick(); tick();
        chk("rst_valid", {31'd0, grantValid}, 32'd0);
        chk("rst_chan", {30'd0, grantChannel}, 32'd0);
        chk("rst_pend", {28'd0, pendingReq}, 32'd0);
        chk("rst_dack", {28'd0, DACK}, 32'd0);
        RESET = 1'b0; settle();

        // Fixed priority, ch1 wins over ch3.
        DREQ = 4'b1010; settle(); tick(); tick();
        chk("fix_chan", {30'd0, grantChannel}, 32'd1);
        chk("fix_valid", {31'd0, grantValid}, 32'd1);
        assertDACK = 1'b1; settle();
        chk("fix_dack", {28'd0, DACK}, 32'h2);
        tick();
        assertDACK = 1'b0; settle(); tick();

        // Masked request never granted.
        do_reset();
        maskReg = 4'b0001; DREQ = 4'b0001; assertDACK = 1'b1; settle();
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("mask_valid", {31'd0, grantValid}, 32'd0);
            chk("mask_dack", {28'd0, DACK}, 32'd0);
        end

        // Active-low sense on both sides.
        assertDACK = 1'b0; maskReg = 4'h0; dreqSenseHigh = 1'b0; dackSenseHigh = 1'b0; DREQ = 4'b1011;
        do_reset();
        tick(); tick();
        chk("low_chan", {30'd0, grantChannel}, 32'd2);
        chk("low_idle_dack", {28'd0, DACK}, 32'hF);
        assertDACK = 1'b1; settle();
        chk("low_dack", {28'd0, DACK}, 32'hB);
        tick();
        assertDACK = 1'b0; settle();
        chk("low_dack_off", {28'd0, DACK}, 32'hF);
        tick();
        dreqSenseHigh = 1'b1; dackSenseHigh = 1'b1; DREQ = 4'h0;

        // Withdrawal while locked: no rotation, ch1 next.
        do_reset();
        DREQ = 4'b0011; settle(); tick(); tick();
        chk("wd_chan0", {30'd0, grantChannel}, 32'd0);
        DREQ = 4'b0010; settle(); tick(); tick();
        chk("wd_idle", {31'd0, grantValid}, 32'd0);
        tick();
        chk("wd_chan1", {30'd0, grantChannel}, 32'd1);
        chk("wd_valid", {31'd0, grantValid}, 32'd1);

        // Rotating order after servicing ch2.
        DREQ = 4'h0; do_reset();
        rotatingPriority = 1'b1; DREQ = 4'b0100; settle(); tick(); tick();
        chk("rot_first", {30'd0, grantChannel}, 32'd2);
        assertDACK = 1'b1; DREQ = 4'h0; settle(); tick();
        intEOP = 1'b1; settle(); tick();
        intEOP = 1'b0; assertDACK = 1'b0; DREQ = 4'b1111; settle();
        for (int i = 0; i < 4; i++) begin
            serve_one(ch);
            chk("rot_order", ch, exp_order[i]);
        end

        // Reset in the middle of a service.
        DREQ = 4'h0; do_reset();
        DREQ = 4'b0100; settle(); tick(); tick();
        assertDACK = 1'b1; settle(); tick();
        chk("rs_dack_pre", {28'd0, DACK}, 32'h4);
        RESET = 1'b1; settle(); tick();
        chk("rs_dack", {28'd0, DACK}, 32'h0);
        chk("rs_valid", {31'd0, grantValid}, 32'd0);
        RESET = 1'b0; assertDACK = 1'b0; DREQ = 4'b1111; settle(); tick(); tick();
        chk("rs_top0", {30'd0, grantChannel}, 32'd0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            RESET = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 3) == 0) DREQ = 4'($urandom);
            maskReg = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            if ($urandom_range(0, 63) == 0) dreqSenseHigh = ~dreqSenseHigh;
            if ($urandom_range(0, 63) == 0) dackSenseHigh = ~dackSenseHigh;
            if ($urandom_range(0, 31) == 0) rotatingPriority = ~rotatingPriority;
            assertDACK = ($urandom_range(0, 2) != 0);
            intEOP = ($urandom_range(0, 5) == 0);
            settle();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/dma_priority_resolver.md
# dma_priority_resolver

Channel arbitration stage of the DMA controller. It samples the four DREQ lines, filters them through the channel mask, and selects one winning channel using fixed or rotating priority. It locks that channel for the duration of a service and drives the DACK line toward the requesting peripheral whenever timing-and-control requests it. It sits directly upstream of the timing-and-control FSM, which consumes `grantValid` (the filtered DREQ summary) and returns `assertDACK`/`intEOP`.

## Interface
- `NUM_CH`, 4: number of DMA channels. Only 4 is supported.
- `CH_W`, 2: channel index width, `$clog2(NUM_CH)`.

Ports (name, direction, width, meaning):
- `CLK` in 1: system clock, all state on rising edge.
- `RESET` in 1: synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `DREQ` in 4: raw peripheral requests, polarity set by `dreqSenseHigh`.
- `dreqSenseHigh` in 1: 1 = DREQ active high; 0 = active low.
- `dackSenseHigh` in 1: 1 = DACK active high; 0 = active low.
- `maskReg` in 4: 1 = channel masked (request ignored).
- `rotatingPriority` in 1: command-register priority bit; 1 = rotating, 0 = fixed.
- `assertDACK` in 1: from timing-and-control; high during the S1/S2 service states.
- `intEOP` in 1: one-cycle end-of-service pulse from timing-and-control.
- `DACK` out 4: per-channel acknowledge, at the level set by `dackSenseHigh`.
- `grantValid` out 1: a channel is locked and awaiting or receiving service.
- `grantChannel` out 2: index of the locked channel.
- `pendingReq` out 4: normalized, unmasked requests (registered), for status readback.

## Operation
- Normalization: `req = (dreqSenseHigh ? DREQ : ~DREQ) & ~maskReg`. This value is registered once into `pendingReq`, giving one synchronizer stage.
- Priority order is held in a 2-bit pointer `topCh`, the highest-priority channel. Order runs `topCh`, `topCh+1`, … modulo 4, so wrap-around is mod-4.
- FSM states:
  - **IDLE:** `grantValid`=0. If `pendingReq` != 0, latch the first set bit in priority order into `grantChannel` and go to LOCKED.
  - **LOCKED:** `grantValid`=1 and `grantChannel` frozen.
    - If `assertDACK`=1, set `serviced`=1 and go to SERVE.
    - If `pendingReq[grantChannel]` drops before any `assertDACK`, return to IDLE with no rotation.
  - **SERVE:** `grantValid`=1.
    - On `intEOP`=1, go to IDLE and apply the rotation rule.
    - If `assertDACK` falls with no `intEOP` (single transfer complete), go to IDLE and apply the rotation rule.
- Rotation rule, applied on SERVE exit: if `rotatingPriority`=1, set `topCh <= grantChannel+1` (mod 4), making the serviced channel lowest. Otherwise `topCh` = 0.
- DACK: `DACK[i]` is active only when `assertDACK`=1, state is not IDLE, and `i==grantChannel`. It is combinational from `assertDACK` so it tracks S1/S2 in the same cycle. At most one DACK is ever active.
- Mask or DREQ changes during SERVE do not change `grantChannel`; the lock persists until exit.
- Simultaneous `intEOP` and a new request: exit to IDLE first. Re-arbitration happens the following cycle using the updated `topCh`.

## Timing
- Reset values:
  - state IDLE, `topCh`=0, `grantValid`=0, `grantChannel`=0, `pendingReq`=0.
  - `DACK` all inactive, i.e. 4'b0000 if `dackSenseHigh`, else 4'b1111.
- Request to `grantValid` latency is 2 cycles: 1 cycle into `pendingReq` and 1 cycle to LOCKED.
- `assertDACK` to `DACK` active latency is 0 cycles (combinational).
- `intEOP` to `grantValid`=0 latency is 1 cycle.
- Earliest re-grant after exit is 2 cycles.
- Mid-operation `RESET`: next edge forces the reset values, aborts any service, and restores fixed order from channel 0.

## Configuration
- `DMA_ROTATING_PRIORITY_EN` defined: `topCh` register and rotation rule are compiled in, and `rotatingPriority` is honoured.
- Not defined: `topCh` is the constant 0 and order is always 0>1>2>3. `rotatingPriority` is ignored; the port stays present but unused.

## Structure
- Shared package `dmaPkg`: `NUM_CH`, `CH_W`, and the `prioState_e` enum (IDLE, LOCKED, SERVE), one-hot encoded to match existing FSMs.
- One sub-module: `dma_rr_pick`. It is combinational; given `req[3:0]` and `topCh`, it returns `winner[1:0]` and `any`. It is reused by status logic.

## Test plan
- Fixed priority, `DREQ`=4'b1010 active-high, no mask -> `grantChannel`=1 two cycles later, `DACK`=4'b0010 while `assertDACK`=1.
- Rotating priority: service ch2, pulse `intEOP`, then `DREQ`=4'b1111 -> next grant is ch3, then ch0, then ch1, then ch2.
- `maskReg`=4'b0001, `DREQ`=4'b0001 -> `grantValid` stays 0 and `DACK` stays inactive for 20 cycles.
- `dreqSenseHigh`=0, `dackSenseHigh`=0, `DREQ`=4'b1011 -> ch2 granted; `DACK`=4'b1011 during `assertDACK`, else 4'b1111.
- Ch0 DREQ withdrawn while LOCKED before `assertDACK` -> returns to IDLE, `topCh` unchanged, ch1 granted next if requesting.
- `RESET` asserted during SERVE with `DACK`=4'b0100 -> next cycle `DACK` inactive, `grantValid`=0, `topCh`=0.
